// File: rtl/udc_mon_pkg.sv
// Shared types for the up/down count monitor: tracker states and the
// step classes produced when one sample is compared with the previous one.
package udc_mon_pkg;

   typedef enum logic [1:0] {
      EMPTY,
      SEEDED,
      TRACK_UP,
      TRACK_DN
   } state_t;

   typedef enum logic [1:0] {
      HOLD,
      UP,
      DN,
      JUMP
   } step_cls_t;

endpackage

// File: rtl/udc_delta_classify.sv
// Combinational step classifier: modular delta between the new and previous
// sample mapped to HOLD/UP/DN/JUMP, plus wrap detection.
// Ports: cnt_in, last_cnt (WIDTH) in; cls, wrap_up, wrap_dn out.
module udc_delta_classify
   import udc_mon_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] cnt_in,
   input  logic [WIDTH-1:0] last_cnt,
   output step_cls_t        cls,
   output logic             wrap_up,
   output logic             wrap_dn
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] TOP = '1;

   logic [WIDTH-1:0] delta;

   // Subtraction wraps naturally modulo 2^WIDTH.
   assign delta = cnt_in - last_cnt;

   always_comb begin
      cls = JUMP;
      if (delta == '0)
         cls = HOLD;
      else if (delta == ONE)
         cls = UP;
      else if (delta == TOP)
         cls = DN;
   end

   assign wrap_up = (last_cnt == TOP) && (cnt_in == '0);
   assign wrap_dn = (last_cnt == '0) && (cnt_in == TOP);

endmodule

// File: rtl/updown_count_monitor.sv
// Observes a count stream and reports direction, steps, wraps and jumps.
// Ports: clk, rst (sync, active-high), cnt_in/cnt_vld in; dir_vld, dir_up,
// step, wrap_up, wrap_dn, jump, jump_cnt, last_cnt out.
// Macro UDC_MON_REVERSAL_CNT_EN adds rev_cnt and reversal outputs.
module updown_count_monitor
   import udc_mon_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int JCNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  cnt_in,
   input  logic              cnt_vld,
   output logic              dir_vld,
   output logic              dir_up,
   output logic              step,
   output logic              wrap_up,
   output logic              wrap_dn,
   output logic              jump,
   output logic [JCNT_W-1:0] jump_cnt,
`ifdef UDC_MON_REVERSAL_CNT_EN
   output logic [JCNT_W-1:0] rev_cnt,
   output logic              reversal,
`endif
   output logic [WIDTH-1:0]  last_cnt
);

   state_t    state;
   step_cls_t cls;
   logic      wu;
   logic      wd;

   udc_delta_classify #(
      .WIDTH (WIDTH)
   ) u_cls (
      .cnt_in   (cnt_in),
      .last_cnt (last_cnt),
      .cls      (cls),
      .wrap_up  (wu),
      .wrap_dn  (wd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EMPTY;
         dir_vld  <= 1'b0;
         dir_up   <= 1'b0;
         step     <= 1'b0;
         wrap_up  <= 1'b0;
         wrap_dn  <= 1'b0;
         jump     <= 1'b0;
         jump_cnt <= '0;
         last_cnt <= '0;
`ifdef UDC_MON_REVERSAL_CNT_EN
         rev_cnt  <= '0;
         reversal <= 1'b0;
`endif
      end else begin
         step    <= 1'b0;
         wrap_up <= 1'b0;
         wrap_dn <= 1'b0;
         jump    <= 1'b0;
`ifdef UDC_MON_REVERSAL_CNT_EN
         reversal <= 1'b0;
`endif
         if (cnt_vld) begin
            last_cnt <= cnt_in;
            if (state == EMPTY) begin
               // First sample only seeds; nothing to compare against.
               state <= SEEDED;
            end else begin
               unique case (cls)
                  HOLD: ;
                  UP: begin
                     state   <= TRACK_UP;
                     dir_vld <= 1'b1;
                     dir_up  <= 1'b1;
                     step    <= 1'b1;
                     wrap_up <= wu;
`ifdef UDC_MON_REVERSAL_CNT_EN
                     if (state == TRACK_DN) begin
                        reversal <= 1'b1;
                        if (rev_cnt != '1)
                           rev_cnt <= rev_cnt + 1'b1;
                     end
`endif
                  end
                  DN: begin
                     state   <= TRACK_DN;
                     dir_vld <= 1'b1;
                     dir_up  <= 1'b0;
                     step    <= 1'b1;
                     wrap_dn <= wd;
`ifdef UDC_MON_REVERSAL_CNT_EN
                     if (state == TRACK_UP) begin
                        reversal <= 1'b1;
                        if (rev_cnt != '1)
                           rev_cnt <= rev_cnt + 1'b1;
                     end
`endif
                  end
                  JUMP: begin
                     // A jump reseeds: direction is unknown again.
                     state   <= SEEDED;
                     dir_vld <= 1'b0;
                     dir_up  <= 1'b0;
                     jump    <= 1'b1;
                     if (jump_cnt != '1)
                        jump_cnt <= jump_cnt + 1'b1;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_updown_count_monitor.sv
// Scoreboard bench for updown_count_monitor: directed scenarios followed by
// random stimulus, checked against an arithmetic reference model.
module tb_updown_count_monitor;

   localparam int W    = 4;
   localparam int JW   = 2;
   localparam int MODV = 16;
   localparam int JMAX = 3;

   logic          clk;
   logic          rst;
   logic [W-1:0]  cnt_in;
   logic          cnt_vld;
   logic          dir_vld;
   logic          dir_up;
   logic          step;
   logic          wrap_up;
   logic          wrap_dn;
   logic          jump;
   logic [JW-1:0] jump_cnt;
   logic [W-1:0]  last_cnt;
`ifdef UDC_MON_REVERSAL_CNT_EN
   logic [JW-1:0] rev_cnt;
   logic          reversal;
`endif

   updown_count_monitor #(
      .WIDTH  (W),
      .JCNT_W (JW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cnt_in   (cnt_in),
      .cnt_vld  (cnt_vld),
      .dir_vld  (dir_vld),
      .dir_up   (dir_up),
      .step     (step),
      .wrap_up  (wrap_up),
      .wrap_dn  (wrap_dn),
      .jump     (jump),
      .jump_cnt (jump_cnt),
`ifdef UDC_MON_REVERSAL_CNT_EN
      .rev_cnt  (rev_cnt),
      .reversal (reversal),
`endif
      .last_cnt (last_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int dv;
      int du;
      int st;
      int wu;
      int wd;
      int jp;
      int jc;
      int lc;
      int rc;
      int rv;
   } exp_t;

   exp_t q[$];

   int checks = 0;
   int errors = 0;

   // Reference model: seeded flag, direction (-1/0/+1), previous value.
   int m_seeded = 0;
   int m_dir    = 0;
   int m_prev   = 0;
   int m_jc     = 0;
   int m_rc     = 0;

   function automatic void check(string n, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", n, act, exp,
                  $time);
      end
   endfunction

   function automatic exp_t model(int r, int v, int val);
      exp_t e;
      int d;
      e.st = 0; e.wu = 0; e.wd = 0; e.jp = 0; e.rv = 0;
      if (r != 0) begin
         m_seeded = 0; m_dir = 0; m_prev = 0; m_jc = 0; m_rc = 0;
      end else if (v != 0) begin
         if (m_seeded == 0) begin
            m_seeded = 1;
         end else begin
            d = (val - m_prev + MODV) % MODV;
            if (d == 1) begin
               if (m_dir == -1) begin
                  e.rv = 1;
                  if (m_rc < JMAX) m_rc++;
               end
               m_dir = 1;
               e.st = 1;
               e.wu = (m_prev == MODV - 1 && val == 0) ? 1 : 0;
            end else if (d == MODV - 1) begin
               if (m_dir == 1) begin
                  e.rv = 1;
                  if (m_rc < JMAX) m_rc++;
               end
               m_dir = -1;
               e.st = 1;
               e.wd = (m_prev == 0 && val == MODV - 1) ? 1 : 0;
            end else if (d != 0) begin
               m_dir = 0;
               e.jp = 1;
               if (m_jc < JMAX) m_jc++;
            end
         end
         m_prev = val;
      end
      e.dv = (m_dir != 0) ? 1 : 0;
      e.du = (m_dir == 1) ? 1 : 0;
      e.jc = m_jc;
      e.lc = m_prev;
      e.rc = m_rc;
      return e;
   endfunction

   task automatic drive(int r, int v, int val);
      @(negedge clk);
      rst     = r[0];
      cnt_vld = v[0];
      cnt_in  = W'(val);
      q.push_back(model(r, v, val));
   endtask

   task automatic seq(int vals[]);
      foreach (vals[i]) drive(0, 1, vals[i]);
   endtask

   // Monitor: the DUT presents a registered result after every edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("dir_vld", int'(dir_vld), e.dv);
            check("dir_up", int'(dir_up), e.du);
            check("step", int'(step), e.st);
            check("wrap_up", int'(wrap_up), e.wu);
            check("wrap_dn", int'(wrap_dn), e.wd);
            check("jump", int'(jump), e.jp);
            check("jump_cnt", int'(jump_cnt), e.jc);
            check("last_cnt", int'(last_cnt), e.lc);
`ifdef UDC_MON_REVERSAL_CNT_EN
            check("rev_cnt", int'(rev_cnt), e.rc);
            check("reversal", int'(reversal), e.rv);
`endif
         end
      end
   end

   initial begin
      int r;
      int val;
      int wait_cyc;
      rst     = 1'b1;
      cnt_vld = 1'b0;
      cnt_in  = '0;
      drive(1, 0, 0);
      drive(1, 1, 9);
      seq('{5});
      seq('{5, 6, 7, 8});
      seq('{14, 15, 0, 15});
      seq('{3, 4, 9, 10});
      seq('{7});
      drive(0, 0, 6);
      drive(0, 0, 9);
      drive(0, 0, 2);
      seq('{6});
      seq('{0, 5, 10, 3, 12, 1});
      seq('{2, 3});
      drive(1, 1, 4);
      seq('{8, 9});
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 9);
         if (r < 2) val = m_prev;
         else if (r < 5) val = (m_prev + 1) % MODV;
         else if (r < 8) val = (m_prev + MODV - 1) % MODV;
         else val = $urandom_range(0, MODV - 1);
         drive(($urandom_range(0, 99) == 0) ? 1 : 0,
               ($urandom_range(0, 9) < 8) ? 1 : 0, val);
      end
      @(negedge clk);
      cnt_vld = 1'b0;
      wait_cyc = 0;
      while (q.size() > 0 && wait_cyc < 10) begin
         @(negedge clk);
         wait_cyc++;
      end
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d expected=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
